// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data-memory bus initiator.
//   state_e    : initiator FSM states (IDLE, ACCESS, RDWAIT)
//   size_e     : access size encoding (SZ_WORD=0, SZ_HALF=1)
//   DEF_*      : default timeout / read-latency settings
//   is_aligned : alignment check of a byte address for a given access size
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_e;

  typedef enum logic {
    SZ_WORD = 1'b0,
    SZ_HALF = 1'b1
  } size_e;

  localparam int DEF_TIMEOUT = 15;
  localparam int DEF_RD_LAT  = 1;

  // Words need both low address bits clear, half-words only bit 0.
  function automatic logic is_aligned(input logic [1:0] lsb, input size_e sz);
    return (sz == SZ_HALF) ? (lsb[0] == 1'b0) : (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_bus_if.sv
// Strobe/acknowledge data-memory bus between an initiator and a responder.
//   stb_o, cyc_o : strobe / cycle (initiator -> responder)
//   we_o         : write enable
//   adr_o        : byte address
//   dat_o        : write data
//   half_w_o     : half-word select
//   signext_o    : 1 = responder zero-extends half-word reads
//   ack_i        : acknowledge (responder -> initiator)
//   dat_i        : read data   (responder -> initiator)
interface mem_bus_if;
  logic        stb_o;
  logic        cyc_o;
  logic        we_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic        half_w_o;
  logic        signext_o;
  logic        ack_i;
  logic [31:0] dat_i;

  modport master (
    output stb_o, cyc_o, we_o, adr_o, dat_o, half_w_o, signext_o,
    input  ack_i, dat_i
  );

  modport slave (
    input  stb_o, cyc_o, we_o, adr_o, dat_o, half_w_o, signext_o,
    output ack_i, dat_i
  );
endinterface

// File: rtl/bus_timeout_ctr.sv
// Watchdog counter for bus initiators.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : clear count to zero (has priority over en_i)
//   en_i     : count this cycle
//   tc_o     : high in the counting cycle that brings the count to TIMEOUT,
//              so the caller can abort on the same edge
module bus_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tc_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mem_bus_master.sv
// Data-memory bus initiator: turns single CPU load/store requests into
// strobe/acknowledge bus transactions, checks alignment, waits out the
// responder's read latency and aborts hung accesses after TIMEOUT cycles.
//   clk, rst                 : clock, asynchronous active-high reset
//   req_i, we_i, addr_i,
//   wdata_i, half_i,
//   signext_i                : CPU request (sampled only while idle)
//   busy_o, done_o, err_o    : status; done_o/err_o are one-cycle pulses
//   rdata_o                  : load result, held until the next load completes
//   bus                      : memory bus, initiator side
// Every output comes straight from a flop.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int RD_LAT  = DEF_RD_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        half_i,
  input  logic        signext_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  mem_bus_if.master   bus
);

  state_e      state_q, state_d;
  logic        stb_q, stb_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        half_q, half_d;
  logic        sext_q, sext_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  lat_q, lat_d;

  logic tmr_clr, tmr_en, tmr_tc;
  logic lat_last;

  bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk  (clk),
    .rst  (rst),
    .clr_i(tmr_clr),
    .en_i (tmr_en),
    .tc_o (tmr_tc)
  );

  assign lat_last = (int'(lat_q) >= RD_LAT - 1);

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    half_d  = half_q;
    sext_d  = sext_q;
    rdata_d = rdata_q;
    lat_d   = lat_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tmr_clr = 1'b1;
    tmr_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          if (!is_aligned(addr_i[1:0], size_e'(half_i))) begin
            err_d = 1'b1;
          end else begin
            state_d = ACCESS;
            stb_d   = 1'b1;
            cyc_d   = 1'b1;
            we_d    = we_i;
            adr_d   = addr_i;
            // Replicate the half-word so the responder can pick either bank.
            dat_d   = half_i ? {wdata_i[15:0], wdata_i[15:0]} : wdata_i;
            half_d  = half_i;
            sext_d  = ~signext_i;
            lat_d   = 2'd0;
          end
        end
      end

      ACCESS: begin
        tmr_clr = 1'b0;
        tmr_en  = ~bus.ack_i;
        // ack_i masks the timer enable, so an ack on the terminal cycle wins.
        if (bus.ack_i) begin
          stb_d = 1'b0;
          if (we_q) begin
            cyc_d   = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (RD_LAT == 0) begin
            rdata_d = bus.dat_i;
            cyc_d   = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RDWAIT;
          end
        end else if (tmr_tc) begin
          stb_d   = 1'b0;
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      RDWAIT: begin
        if (lat_last) begin
          rdata_d = bus.dat_i;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end

      default: begin
        state_d = IDLE;
        stb_d   = 1'b0;
        cyc_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      half_q  <= 1'b0;
      sext_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      lat_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      half_q  <= half_d;
      sext_q  <= sext_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      lat_q   <= lat_d;
    end
  end

  assign bus.stb_o     = stb_q;
  assign bus.cyc_o     = cyc_q;
  assign bus.we_o      = we_q;
  assign bus.adr_o     = adr_q;
  assign bus.dat_o     = dat_q;
  assign bus.half_w_o  = half_q;
  assign bus.signext_o = sext_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign rdata_o       = rdata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master (TIMEOUT=15, RD_LAT=1) with a small
// 16-word responder: ack is combinational from stb, read data is registered
// one cycle after the read ack.
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        half_i = 1'b0;
  logic        signext_i = 1'b0;
  logic        busy_o, done_o, err_o;
  logic [31:0] rdata_o;

  logic        ack_en = 1'b1;
  logic        mem_clr = 1'b1;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;
  logic [31:0] mem [0:15];
  logic [31:0] rd_reg;

  int n_chk = 0;
  int n_fail = 0;

  mem_bus_if bus ();

  mem_bus_master #(.TIMEOUT(15), .RD_LAT(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .half_i   (half_i),
    .signext_i(signext_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .rdata_o  (rdata_o),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.ack_i = ack_en & bus.stb_o;
  assign bus.dat_i = rd_reg;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      rd_reg <= '0;
    end else if (bus.stb_o && bus.ack_i) begin
      if (bus.we_o) begin
        if (!bus.half_w_o)     mem[bus.adr_o[5:2]]        <= bus.dat_o;
        else if (bus.adr_o[1]) mem[bus.adr_o[5:2]][31:16] <= bus.dat_o[31:16];
        else                   mem[bus.adr_o[5:2]][15:0]  <= bus.dat_o[15:0];
      end else begin
        rd_reg <= ovr_en ? ovr_val : mem[bus.adr_o[5:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Presents a request before edge E0 and drops it just after; returns in cycle 0.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic hf, input logic se);
    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd; half_i = hf; signext_i = se;
    @(posedge clk);
    #1 req_i = 1'b0;
  endtask

  int stb_cnt, done_cnt, err_cyc;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_bus", {27'd0, bus.stb_o, bus.cyc_o, bus.we_o, bus.half_w_o, bus.signext_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    rst = 1'b0;
    mem_clr = 1'b0;

    // Word store, immediate ack
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
    @(negedge clk);
    check("st_c1_stb_cyc_we", {29'd0, bus.stb_o, bus.cyc_o, bus.we_o}, 32'h7);
    check("st_c1_adr", bus.adr_o, 32'h10);
    check("st_c1_dat", bus.dat_o, 32'hDEAD_BEEF);
    check("st_c1_busy_done", {30'd0, busy_o, done_o}, 32'h2);
    @(negedge clk);
    check("st_c2_stb_done", {30'd0, bus.stb_o, done_o}, 32'h1);
    check("st_c2_rdata", rdata_o, 32'd0);

    // Word load readback
    issue(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("ld_c1_stb_we", {30'd0, bus.stb_o, bus.we_o}, 32'h2);
    @(negedge clk);
    check("ld_c2_stb_cyc_done", {29'd0, bus.stb_o, bus.cyc_o, done_o}, 32'h2);
    check("ld_c2_adr", bus.adr_o, 32'h10);
    @(negedge clk);
    check("ld_c3_done_cyc", {30'd0, done_o, bus.cyc_o}, 32'h2);
    check("ld_c3_rdata", rdata_o, 32'hDEAD_BEEF);

    // Half load with sign extension requested
    ovr_en = 1'b1; ovr_val = 32'h0000_8001;
    issue(1'b0, 32'h12, 32'h0, 1'b1, 1'b1);
    done_cnt = 0;
    @(negedge clk);
    check("hld_c1_half_sext", {30'd0, bus.half_w_o, bus.signext_o}, 32'h2);
    check("hld_c1_adr", bus.adr_o, 32'h12);
    done_cnt += int'(done_o);
    @(negedge clk);
    done_cnt += int'(done_o);
    @(negedge clk);
    check("hld_c3_rdata", rdata_o, 32'h0000_8001);
    done_cnt += int'(done_o);
    repeat (2) begin
      @(negedge clk);
      done_cnt += int'(done_o);
    end
    check("hld_done_count", 32'(done_cnt), 32'd1);
    ovr_en = 1'b0;

    // Misaligned word load
    issue(1'b0, 32'h6, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("mis_c1_err_stb_busy", {29'd0, err_o, bus.stb_o, busy_o}, 32'h4);
    @(negedge clk);
    check("mis_c2_err_stb_busy", {29'd0, err_o, bus.stb_o, busy_o}, 32'h0);
    check("mis_rdata", rdata_o, 32'h0000_8001);

    // Timeout with no ack
    ack_en = 1'b0;
    issue(1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
    stb_cnt = 0; done_cnt = 0; err_cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      stb_cnt += int'(bus.stb_o);
      done_cnt += int'(done_o);
      if (err_o && err_cyc == 0) err_cyc = c;
    end
    check("to_stb_cycles", 32'(stb_cnt), 32'd15);
    check("to_err_cycle", 32'(err_cyc), 32'd16);
    check("to_no_done", 32'(done_cnt), 32'd0);
    check("to_rdata", rdata_o, 32'h0000_8001);
    ack_en = 1'b1;

    // Half store to upper bank, then word load of the same word
    issue(1'b1, 32'h22, 32'h1234_5678, 1'b1, 1'b0);
    @(negedge clk);
    check("hst_c1_dat", bus.dat_o, 32'h5678_5678);
    @(negedge clk);
    check("hst_c2_done", 32'(done_o), 32'd1);
    issue(1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("hst_rdback", rdata_o, 32'h5678_0000);

    // Asynchronous reset while in RDWAIT
    issue(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rw_cyc_stb", {30'd0, bus.cyc_o, bus.stb_o}, 32'h2);
    #1 rst = 1'b1;
    #1;
    check("rw_rst_ctl", {25'd0, bus.stb_o, bus.cyc_o, bus.we_o, bus.half_w_o,
                         busy_o, done_o, err_o}, 32'd0);
    check("rw_rst_adr", bus.adr_o, 32'd0);
    check("rw_rst_rdata", rdata_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      done_cnt += int'(done_o);
    end
    check("rw_no_done", 32'(done_cnt), 32'd0);
    issue(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("rw_reload", rdata_o, 32'hDEAD_BEEF);

    // Back-to-back with req held high
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h24; wdata_i = 32'hCAFE_F00D; half_i = 1'b0;
    stb_cnt = 0;
    @(negedge clk);                 // cycle 1: store strobe
    stb_cnt += int'(bus.stb_o);
    we_i = 1'b0;                    // next request becomes a load of the same word
    @(negedge clk);                 // cycle 2: store done
    check("b2b_c2_done", 32'(done_o), 32'd1);
    stb_cnt += int'(bus.stb_o);
    @(negedge clk);                 // cycle 3: load strobe
    check("b2b_c3_stb_we", {30'd0, bus.stb_o, bus.we_o}, 32'h2);
    stb_cnt += int'(bus.stb_o);
    @(negedge clk);                 // cycle 4: RDWAIT, req still high but ignored
    stb_cnt += int'(bus.stb_o);
    req_i = 1'b0;
    @(negedge clk);                 // cycle 5: load done
    check("b2b_c5_rdata", rdata_o, 32'hCAFE_F00D);
    stb_cnt += int'(bus.stb_o);
    repeat (3) begin
      @(negedge clk);
      stb_cnt += int'(bus.stb_o);
    end
    check("b2b_stb_total", 32'(stb_cnt), 32'd2);
    check("b2b_idle_busy", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
